apb_irq_ctrl: RTL and testbench
===============================

Name: apb_irq_ctrl

Overview:
- APB3 slave interrupt aggregator sitting directly downstream of the APB timer instances and other peripherals.
- Collects per-source interrupt lines (e.g. timerint), synchronises them and latches pending state per source (edge or level mode).
- Applies per-source enables and drives one registered irq_out plus a registered lowest-index active source ID to the CPU.
- Same 12-bit APB window style as the timer: 0x000-0xFFF, word addressed.

Parameters:
- NUM_IRQ, 8, number of interrupt sources; legal range 1..32.

Ports:
- pclkg  in  1  APB/gated clock; all state on this clock.
- presetn  in  1  reset.
- psel  in  1  APB select.
- paddr  in  10 [11:2]  word address.
- penable  in  1  APB enable phase.
- pwrite  in  1  APB write.
- pwdata  in  32  write data.
- prdata  out  32  read data.
- pready  out  1  tied 1.
- pslverr  out  1  tied 0.
- irq_src  in  NUM_IRQ  asynchronous interrupt inputs; bit i is source i.
- irq_out  out  1  combined interrupt to CPU, registered.
- irq_valid  out  1  at least one active source, registered.
- irq_id  out  5  lowest-index active source, registered; 0 when irq_valid=0.

Behaviour:
- Reset: presetn is asynchronous and active-low; the block is clocked on pclkg.
- Reset values: all registers, synchronisers, pending bits, irq_out, irq_valid and irq_id are 0.
- Write strobe: psel & pwrite & ~penable, i.e. the setup phase. Exactly one pclkg edge commits the write.
- Read: prdata = mux(paddr) when psel & ~pwrite, else 0. Reads are combinational with no side effects.
- Unmapped addresses read 0 and ignore writes.
- Register map:
  - 0x000 RAW: RO, synchronised irq_src (sync2).
  - 0x004 ENABLE: RW, NUM_IRQ bits.
  - 0x008 PENDING: RO on read; write-1-to-clear, effective for edge-mode bits only.
  - 0x00C EDGE: RW; 1 = rising-edge sticky, 0 = level.
  - 0x010 SWSET: WO, reads 0; write-1 sets pending, effective for edge-mode bits only.
  - 0x014 ACTIVE: RO, PENDING & ENABLE.
  - 0x018 ID: RO, {26'b0, irq_valid, irq_id}, packed {bit5 valid, bits4:0 id}.
- Register bits above NUM_IRQ-1 read 0 and ignore writes.
- Per-source synchroniser: sync1 <= irq_src[i]; sync2 <= sync1; dly <= sync2. rise = sync2 & ~dly.
- Pending, level mode: pending[i] <= sync2[i] every cycle. W1C and SWSET have no effect.
- Pending, edge mode: pending[i] <= (pending[i] & ~clr[i]) | rise[i] | swset[i].
- Simultaneous set and clear in the same cycle: set wins, bit stays 1.
- Changing EDGE from 1 to 0: pending follows sync2 from the next edge.
- Changing EDGE from 0 to 1: the current pending value is kept (sticky).
- Output stage, registered from the current pending & enable:
  - irq_out <= |(pending & enable).
  - irq_valid <= same value as irq_out.
  - irq_id <= index of the lowest set bit of pending & enable, or 0 if none.
- Latency: an irq_src rising edge sampled at edge N gives sync2=1 after N+1, pending=1 after N+2, irq_out/irq_id valid after N+3.
- Clear latency: a W1C committed at edge M drops pending at M; irq_out falls after M+1 if nothing else is active.
- Enable of an already-pending source: irq_out rises one edge after the ENABLE write commits.
- Pulses shorter than one pclkg period may be missed; sources must hold for at least 2 cycles, which the timer guarantees.
- Reset asserted mid-operation clears everything immediately; any in-flight edge is lost.

Decomposition:
- Shared package apb_irq_ctrl_pkg:
  - address offset constants for RAW, ENABLE, PENDING, EDGE, SWSET, ACTIVE and ID;
  - NUM_IRQ_MAX = 32;
  - ID width constant = 5.
- One sub-module, irq_src_sync:
  - single-bit 3-flop synchroniser plus rising-edge detect;
  - ports clk, rstn, in, sync, rise;
  - instantiated NUM_IRQ times via generate.
- The priority encoder stays inline.

Test Plan:
1. Reset, then read all addresses 0x000-0x018 -> all return 0; irq_out=0, irq_id=0, pready=1, pslverr=0.
2. EDGE=0xFF, ENABLE=0x04, pulse irq_src[2] high for 3 cycles -> irq_out=1 exactly 3 edges after the sample edge; ID reads 0x22; PENDING=0x04. Write 0x04 to PENDING -> irq_out=0 one edge later; PENDING=0.
3. Level mode (EDGE=0), ENABLE=0x01, hold irq_src[0]=1 -> irq_out=1. W1C 0x01 -> PENDING stays 0x01. Drop irq_src[0] -> PENDING=0 two edges later and irq_out=0 one edge after that.
4. Priority: edge mode, ENABLE=0xFF, SWSET=0xA0 -> ID reads 0x25. W1C 0x20 -> ID reads 0x27. W1C 0x80 -> ID reads 0x00, irq_out=0.
5. Set/clear collision: a rising edge on irq_src[1] reaches the pending update on the same edge that a W1C 0x02 commits -> PENDING bit1 stays 1.
6. Masking: edge mode, ENABLE=0, SWSET=0x08 -> PENDING=0x08, ACTIVE=0, irq_out=0. Write ENABLE=0x08 -> irq_out=1 one edge later, ID reads 0x23. Assert presetn low mid-sequence -> all state returns to 0 asynchronously.

Source files
------------

// File: rtl/apb_irq_ctrl_pkg.sv
// Shared constants for the APB interrupt aggregator: register word addresses
// and sizing limits.
package apb_irq_ctrl_pkg;

  localparam int NUM_IRQ_MAX = 32;
  localparam int ID_W        = 5;

  // Word addresses (byte offset >> 2) inside the 12-bit APB window
  localparam logic [9:0] ADDR_RAW     = 10'h000;
  localparam logic [9:0] ADDR_ENABLE  = 10'h001;
  localparam logic [9:0] ADDR_PENDING = 10'h002;
  localparam logic [9:0] ADDR_EDGE    = 10'h003;
  localparam logic [9:0] ADDR_SWSET   = 10'h004;
  localparam logic [9:0] ADDR_ACTIVE  = 10'h005;
  localparam logic [9:0] ADDR_ID      = 10'h006;

endpackage

// File: rtl/irq_src_sync.sv
// Single-bit two-flop synchroniser with a third delay flop for rising-edge
// detection of an asynchronous interrupt line.
module irq_src_sync
  import apb_irq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic sync,
  output logic rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_dly;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  assign sync = r_sync2;
  assign rise = r_sync2 & ~r_dly;

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB3 interrupt aggregator: synchronises per-source lines, latches pending
// state (edge or level), masks with ENABLE and drives a registered IRQ and ID.
module apb_irq_ctrl
  import apb_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               pclkg,
  input  logic               presetn,
  input  logic               psel,
  input  logic [11:2]        paddr,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               irq_out,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id
);

  logic [NUM_IRQ-1:0] w_sync;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] r_enable;
  logic [NUM_IRQ-1:0] r_edge;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] w_active;
  logic [NUM_IRQ-1:0] w_wdata;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_swset;
  logic               w_wr;
  logic               w_anyActive;
  logic [ID_W-1:0]    w_lowId;
  logic               r_irqOut;
  logic               r_irqValid;
  logic [ID_W-1:0]    r_irqId;
  logic               w_unusedWdata;

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
    irq_src_sync u_sync (
      .clk  (pclkg),
      .rstn (presetn),
      .in   (irq_src[gi]),
      .sync (w_sync[gi]),
      .rise (w_rise[gi])
    );
  end

  // Writes commit in the setup phase so exactly one edge sees the strobe
  assign w_wr          = psel & pwrite & ~penable;
  assign w_wdata       = pwdata[NUM_IRQ-1:0];
  assign w_unusedWdata = ^pwdata;
  assign w_clr         = (w_wr && paddr == ADDR_PENDING) ? w_wdata : '0;
  assign w_swset       = (w_wr && paddr == ADDR_SWSET)   ? w_wdata : '0;
  assign w_active      = r_pending & r_enable;
  assign w_anyActive   = |w_active;

  always_ff @(posedge pclkg or negedge presetn) begin
    if (!presetn) begin
      r_enable <= '0;
      r_edge   <= '0;
    end else if (w_wr) begin
      if (paddr == ADDR_ENABLE) r_enable <= w_wdata;
      if (paddr == ADDR_EDGE)   r_edge   <= w_wdata;
    end
  end

  // Edge bits are sticky with set winning over clear; level bits track sync2
  always_ff @(posedge pclkg or negedge presetn) begin
    if (!presetn) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_edge & ((r_pending & ~w_clr) | w_rise | w_swset))
                 | (~r_edge & w_sync);
    end
  end

  always_comb begin
    w_lowId = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) w_lowId = ID_W'(i);
    end
  end

  always_ff @(posedge pclkg or negedge presetn) begin
    if (!presetn) begin
      r_irqOut   <= 1'b0;
      r_irqValid <= 1'b0;
      r_irqId    <= '0;
    end else begin
      r_irqOut   <= w_anyActive;
      r_irqValid <= w_anyActive;
      r_irqId    <= w_lowId;
    end
  end

  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (paddr)
        ADDR_RAW:     prdata = 32'(w_sync);
        ADDR_ENABLE:  prdata = 32'(r_enable);
        ADDR_PENDING: prdata = 32'(r_pending);
        ADDR_EDGE:    prdata = 32'(r_edge);
        ADDR_ACTIVE:  prdata = 32'(w_active);
        ADDR_ID:      prdata = 32'({r_irqValid, r_irqId});
        default:      prdata = '0;
      endcase
    end
  end

  assign pready    = 1'b1;
  assign pslverr   = 1'b0;
  assign irq_out   = r_irqOut;
  assign irq_valid = r_irqValid;
  assign irq_id    = r_irqId;

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Scoreboard bench for apb_irq_ctrl: expectations are queued as stimulus is
// driven and popped when the matching read data or output pins are sampled.
module tb_apb_irq_ctrl;
  import apb_irq_ctrl_pkg::*;

  localparam int NUM_IRQ = 8;

  logic               pclkg = 1'b0;
  logic               presetn;
  logic               psel;
  logic [9:0]         paddr;
  logic               penable;
  logic               pwrite;
  logic [31:0]        pwdata;
  logic [31:0]        prdata;
  logic               pready;
  logic               pslverr;
  logic [NUM_IRQ-1:0] irq_src;
  logic               irq_out;
  logic               irq_valid;
  logic [ID_W-1:0]    irq_id;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sbItem_t;

  sbItem_t sbQ[$];
  int      testCount = 0;
  int      failCount = 0;

  apb_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
    .pclkg     (pclkg),
    .presetn   (presetn),
    .psel      (psel),
    .paddr     (paddr),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .irq_src   (irq_src),
    .irq_out   (irq_out),
    .irq_valid (irq_valid),
    .irq_id    (irq_id)
  );

  always #5 pclkg = ~pclkg;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExpect(input string tag, input logic [31:0] exp);
    sbItem_t it;
    it.tag = tag;
    it.exp = exp;
    sbQ.push_back(it);
  endtask

  task automatic popCompare(input logic [31:0] obs);
    sbItem_t it;
    if (sbQ.size() == 0) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL sbUnderflow: observed 0x%0h with no expectation queued", obs);
    end else begin
      it = sbQ.pop_front();
      checkOutput(it.tag, obs, it.exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pclkg);
  endtask

  // APB write: setup phase (commit edge) then access phase, ends on a negedge
  task automatic applyStimulus(input logic [9:0] addr, input logic [31:0] data);
    psel    = 1'b1;
    pwrite  = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    pwdata  = data;
    @(negedge pclkg);
    penable = 1'b1;
    @(negedge pclkg);
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic readExpect(input logic [9:0] addr, input string tag, input logic [31:0] exp);
    pushExpect(tag, exp);
    psel    = 1'b1;
    pwrite  = 1'b0;
    penable = 1'b0;
    paddr   = addr;
    #1;
    popCompare(prdata);
    psel    = 1'b0;
    @(negedge pclkg);
  endtask

  task automatic checkIrq(input string tag, input logic expOut, input logic [ID_W-1:0] expId);
    pushExpect(tag, 32'({expOut, expOut, expId}));
    popCompare(32'({irq_out, irq_valid, irq_id}));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    presetn = 1'b0;
    psel    = 1'b0;
    paddr   = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    pwdata  = '0;
    irq_src = '0;
    tick(2);
    presetn = 1'b1;
    tick(1);

    $display("[TB] reset values");
    for (int a = 0; a <= 6; a++) readExpect(10'(a), $sformatf("rst_addr%0d", a), 32'h0);
    checkIrq("rst_irq", 1'b0, 5'd0);
    pushExpect("pready", 32'h1);
    popCompare(32'(pready));
    pushExpect("pslverr", 32'h0);
    popCompare(32'(pslverr));

    $display("[TB] edge-mode latency and W1C");
    applyStimulus(ADDR_EDGE, 32'hFF);
    applyStimulus(ADDR_ENABLE, 32'h04);
    irq_src[2] = 1'b1;
    tick(3);
    checkIrq("edge_early", 1'b0, 5'd0);
    tick(1);
    checkIrq("edge_lat3", 1'b1, 5'd2);
    irq_src[2] = 1'b0;
    readExpect(ADDR_ID, "edge_id", 32'h22);
    readExpect(ADDR_PENDING, "edge_pend", 32'h04);
    applyStimulus(ADDR_PENDING, 32'h04);
    checkIrq("edge_clr_irq", 1'b0, 5'd0);
    readExpect(ADDR_PENDING, "edge_clr_pend", 32'h0);

    $display("[TB] level mode");
    applyStimulus(ADDR_EDGE, 32'h0);
    applyStimulus(ADDR_ENABLE, 32'h01);
    irq_src[0] = 1'b1;
    tick(4);
    checkIrq("lvl_irq", 1'b1, 5'd0);
    applyStimulus(ADDR_PENDING, 32'h01);
    readExpect(ADDR_PENDING, "lvl_w1c_noop", 32'h01);
    applyStimulus(ADDR_SWSET, 32'h02);
    readExpect(ADDR_PENDING, "lvl_swset_noop", 32'h01);
    irq_src[0] = 1'b0;
    tick(2);
    readExpect(ADDR_PENDING, "lvl_pend_hold", 32'h01);
    checkIrq("lvl_irq_hold", 1'b1, 5'd0);
    readExpect(ADDR_PENDING, "lvl_pend_drop", 32'h0);
    checkIrq("lvl_irq_drop", 1'b0, 5'd0);

    $display("[TB] priority, masking of high bits, unmapped");
    applyStimulus(ADDR_EDGE, 32'hFF);
    applyStimulus(ADDR_ENABLE, 32'hFFFF_FFFF);
    readExpect(ADDR_ENABLE, "enable_width", 32'hFF);
    applyStimulus(ADDR_SWSET, 32'hA0);
    readExpect(ADDR_SWSET, "swset_reads0", 32'h0);
    readExpect(ADDR_PENDING, "prio_pend", 32'hA0);
    readExpect(ADDR_ACTIVE, "prio_active", 32'hA0);
    readExpect(ADDR_ID, "prio_id5", 32'h25);
    applyStimulus(ADDR_PENDING, 32'h20);
    readExpect(ADDR_ID, "prio_id7", 32'h27);
    applyStimulus(ADDR_PENDING, 32'h80);
    readExpect(ADDR_ID, "prio_none", 32'h0);
    checkIrq("prio_irq0", 1'b0, 5'd0);
    applyStimulus(10'h008, 32'hFFFF_FFFF);
    readExpect(10'h008, "unmapped", 32'h0);
    readExpect(10'h3FF, "unmapped_top", 32'h0);

    $display("[TB] set/clear collision");
    irq_src[1] = 1'b1;
    tick(2);
    applyStimulus(ADDR_PENDING, 32'h02);
    readExpect(ADDR_PENDING, "collide_set_wins", 32'h02);
    readExpect(ADDR_ID, "collide_id", 32'h21);
    applyStimulus(ADDR_PENDING, 32'h02);
    readExpect(ADDR_PENDING, "collide_later_clr", 32'h0);
    irq_src[1] = 1'b0;
    tick(3);

    $display("[TB] masking, raw and async reset");
    applyStimulus(ADDR_ENABLE, 32'h0);
    applyStimulus(ADDR_SWSET, 32'h08);
    readExpect(ADDR_PENDING, "mask_pend", 32'h08);
    readExpect(ADDR_ACTIVE, "mask_active", 32'h0);
    checkIrq("mask_irq", 1'b0, 5'd0);
    applyStimulus(ADDR_ENABLE, 32'h08);
    checkIrq("unmask_irq", 1'b1, 5'd3);
    readExpect(ADDR_ID, "unmask_id", 32'h23);
    irq_src = 8'h5A;
    tick(2);
    readExpect(ADDR_RAW, "raw", 32'h5A);
    tick(1);
    checkIrq("pre_reset_irq", 1'b1, 5'd3);
    #2;
    presetn = 1'b0;
    #1;
    checkIrq("reset_irq", 1'b0, 5'd0);
    readExpect(ADDR_ENABLE, "reset_enable", 32'h0);
    readExpect(ADDR_EDGE, "reset_edge", 32'h0);
    readExpect(ADDR_PENDING, "reset_pend", 32'h0);
    readExpect(ADDR_RAW, "reset_raw", 32'h0);
    irq_src = '0;
    presetn = 1'b1;
    tick(4);
    readExpect(ADDR_PENDING, "post_reset_pend", 32'h0);
    checkIrq("post_reset_irq", 1'b0, 5'd0);

    checkOutput("sbDrained", 32'(sbQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
